// File: rtl/entrada_handshake.sv
// IN-instruction responder: stalls the datapath until a debounced press+release of
// botaoIN confirms the switches, then presents them on DadosLidos with a one-cycle dadoPronto.
module entrada_handshake #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SYNC_STAGES     = 2,
   parameter int DATA_W          = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        entradaSaidaControl,
   input  logic [DATA_W-1:0] entradaDeDados,
   input  logic              botaoIN,
   output logic [31:0]       DadosLidos,
   output logic              haltIN,
   output logic              dadoPronto
);

   localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] S_IDLE         = 2'd0;
   localparam logic [1:0] S_WAIT_PRESS   = 2'd1;
   localparam logic [1:0] S_WAIT_RELEASE = 2'd2;
   localparam logic [1:0] S_DONE         = 2'd3;

   logic [SYNC_N-1:0] r_sync;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_btn_db;
   logic              r_btn_db_d;
   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic              w_btn_s;
   logic              w_rise;
   logic              w_fall;
   logic              w_req;
   logic              w_capture;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_N-2:0], botaoIN};
      end
   end

   assign w_btn_s = r_sync[SYNC_N-1];

   // The debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_btn_db   <= 1'b0;
         r_btn_db_d <= 1'b0;
      end else begin
         r_btn_db_d <= r_btn_db;
         if (w_btn_s == r_btn_db) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_btn_db <= w_btn_s;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign w_rise    = r_btn_db & ~r_btn_db_d;
   assign w_fall    = ~r_btn_db & r_btn_db_d;
   assign w_req     = (entradaSaidaControl == 2'b10);
   assign w_capture = (r_state == S_WAIT_PRESS) && w_req && w_rise;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req) w_state_next = S_WAIT_PRESS;
         end
         S_WAIT_PRESS: begin
            if (!w_req)      w_state_next = S_IDLE;
            else if (w_rise) w_state_next = S_WAIT_RELEASE;
         end
         S_WAIT_RELEASE: begin
            if (!w_req)      w_state_next = S_IDLE;
            else if (w_fall) w_state_next = S_DONE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         DadosLidos <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_capture) DadosLidos <= 32'(entradaDeDados);
      end
   end

   // Mealy term in IDLE lets the stall cover the request cycle itself.
   assign haltIN     = reset && (((r_state == S_IDLE) && w_req) ||
                                 (r_state == S_WAIT_PRESS) ||
                                 (r_state == S_WAIT_RELEASE));
   assign dadoPronto = (r_state == S_DONE);

endmodule

// File: tb/tb_entrada_handshake.sv
// Bench for entrada_handshake: directed scenarios plus random button/request traffic,
// every cycle compared against a behavioural model of the handshake.
module tb_entrada_handshake;

   localparam int DC = 4;
   localparam int SS = 2;

   localparam int P_IDLE = 0, P_ARMED = 1, P_HELD = 2, P_DONE = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  ctrl = 2'b10;
   logic [3:0]  sw = 4'h0;
   logic        botaoIN = 1'b1;
   logic [31:0] DadosLidos;
   logic        haltIN;
   logic        dadoPronto;

   int n_checks = 0;
   int n_errors = 0;
   int n_pulses = 0;

   // behavioural model state
   bit          m_q[$];
   bit          m_db, m_db_prev;
   int          m_run;
   int          m_phase;
   logic [31:0] m_data;

   entrada_handshake #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS), .DATA_W(4)) dut (
      .clk                 (clk),
      .reset               (reset),
      .entradaSaidaControl (ctrl),
      .entradaDeDados      (sw),
      .botaoIN             (botaoIN),
      .DadosLidos          (DadosLidos),
      .haltIN              (haltIN),
      .dadoPronto          (dadoPronto)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock edge of the model, using the inputs present at that edge.
   task automatic model_edge();
      bit s_pre, rise, fall, req;
      if (!reset) begin
         m_q.delete();
         repeat (SS) m_q.push_back(1'b0);
         m_db = 0; m_db_prev = 0; m_run = 0;
         m_phase = P_IDLE; m_data = 32'h0;
         return;
      end
      s_pre = m_q.pop_front();
      m_q.push_back(botaoIN);
      rise = m_db && !m_db_prev;
      fall = !m_db && m_db_prev;
      m_db_prev = m_db;
      if (s_pre != m_db) begin
         m_run++;
         if (m_run == DC) begin
            m_db  = s_pre;
            m_run = 0;
         end
      end else begin
         m_run = 0;
      end
      req = (ctrl == 2'b10);
      case (m_phase)
         P_IDLE:  if (req) m_phase = P_ARMED;
         P_ARMED: if (!req) m_phase = P_IDLE;
                  else if (rise) begin m_data = {28'h0, sw}; m_phase = P_HELD; end
         P_HELD:  if (!req) m_phase = P_IDLE;
                  else if (fall) m_phase = P_DONE;
         default: m_phase = P_IDLE;
      endcase
   endtask

   task automatic step();
      logic exp_halt;
      @(posedge clk);
      model_edge();
      #1;
      exp_halt = reset && ((m_phase == P_IDLE && ctrl == 2'b10) ||
                           m_phase == P_ARMED || m_phase == P_HELD);
      chk("DadosLidos", DadosLidos, m_data);
      chk("haltIN", {31'h0, haltIN}, {31'h0, exp_halt});
      chk("dadoPronto", {31'h0, dadoPronto}, {31'h0, m_phase == P_DONE});
      if (dadoPronto === 1'b1) n_pulses++;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic wait_pronto(input string tag, input int max);
      bit ok = 0;
      for (int i = 0; i < max; i++) begin
         step();
         if (dadoPronto === 1'b1) begin ok = 1; break; end
      end
      chk(tag, {31'h0, ok}, 32'h1);
   endtask

   task automatic wait_data(input logic [31:0] v, input int max, output int n);
      n = -1;
      for (int i = 0; i < max; i++) begin
         step();
         if (DadosLidos === v) begin n = i + 1; break; end
      end
   endtask

   initial begin
      int lat;
      int hold;
      repeat (SS) m_q.push_back(1'b0);

      // 1: reset held with button pressed and request present
      #2;
      run(3);
      chk("rst_data", DadosLidos, 32'h0);
      chk("rst_halt", {31'h0, haltIN}, 32'h0);
      chk("rst_pronto", {31'h0, dadoPronto}, 32'h0);
      $display("T1 reset: DadosLidos=%h haltIN=%b dadoPronto=%b", DadosLidos, haltIN, dadoPronto);
      reset = 1'b1; botaoIN = 1'b0; ctrl = 2'b00;
      run(10);

      // 2: normal IN
      n_pulses = 0;
      sw = 4'hA; ctrl = 2'b10;
      #1;
      chk("t2_halt_req", {31'h0, haltIN}, 32'h1);
      botaoIN = 1'b1;
      run(10);
      botaoIN = 1'b0;
      wait_pronto("t2_pronto_timeout", 30);
      chk("t2_halt_done", {31'h0, haltIN}, 32'h0);
      ctrl = 2'b00;
      run(5);
      chk("t2_data", DadosLidos, 32'h0000000A);
      chk("t2_pulses", n_pulses, 1);
      $display("T2 normal: DadosLidos=%h pulses=%0d", DadosLidos, n_pulses);

      // 3: bouncing press, capture 7 cycles after the last stable edge
      n_pulses = 0;
      sw = 4'h7; ctrl = 2'b10;
      for (int i = 0; i < 12; i++) begin
         botaoIN = ((i / 2) % 2 == 0);
         step();
      end
      chk("t3_no_early", DadosLidos, 32'h0000000A);
      botaoIN = 1'b1;
      wait_data(32'h7, 20, lat);
      chk("t3_latency", lat, SS + DC + 1);
      run(5);
      botaoIN = 1'b0;
      wait_pronto("t3_pronto_timeout", 30);
      ctrl = 2'b00;
      run(3);
      chk("t3_pulses", n_pulses, 1);
      $display("T3 bounce: capture latency=%0d DadosLidos=%h", lat, DadosLidos);

      // 4: button already held at request time
      n_pulses = 0;
      botaoIN = 1'b1; sw = 4'hC;
      run(10);
      ctrl = 2'b10;
      run(20);
      chk("t4_held_data", DadosLidos, 32'h7);
      chk("t4_held_halt", {31'h0, haltIN}, 32'h1);
      sw = 4'h3; botaoIN = 1'b0;
      run(10);
      chk("t4_rel_data", DadosLidos, 32'h7);
      botaoIN = 1'b1;
      wait_data(32'h3, 20, lat);
      chk("t4_capture", lat, SS + DC + 1);
      run(5);
      botaoIN = 1'b0;
      wait_pronto("t4_pronto_timeout", 30);
      ctrl = 2'b00;
      run(3);
      chk("t4_data", DadosLidos, 32'h3);
      $display("T4 pre-held: DadosLidos=%h pulses=%0d", DadosLidos, n_pulses);

      // 5: abort while waiting for the press
      n_pulses = 0;
      sw = 4'hE; ctrl = 2'b10;
      run(3);
      ctrl = 2'b00;
      step();
      chk("t5_halt", {31'h0, haltIN}, 32'h0);
      run(3);
      chk("t5_data", DadosLidos, 32'h3);
      chk("t5_pulses", n_pulses, 0);
      $display("T5 abort: haltIN=%b DadosLidos=%h pulses=%0d", haltIN, DadosLidos, n_pulses);

      // 6: back-to-back requests with ctrl held high through DONE
      n_pulses = 0;
      sw = 4'h6; ctrl = 2'b10;
      botaoIN = 1'b1;
      run(10);
      botaoIN = 1'b0;
      wait_pronto("t6_first_timeout", 30);
      chk("t6_first_data", DadosLidos, 32'h6);
      sw = 4'h5;
      step();
      chk("t6_rearm_halt", {31'h0, haltIN}, 32'h1);
      chk("t6_rearm_pronto", {31'h0, dadoPronto}, 32'h0);
      botaoIN = 1'b1;
      run(10);
      botaoIN = 1'b0;
      wait_pronto("t6_second_timeout", 30);
      ctrl = 2'b00;
      run(3);
      chk("t6_data", DadosLidos, 32'h5);
      chk("t6_pulses", n_pulses, 2);
      $display("T6 back-to-back: DadosLidos=%h pulses=%0d", DadosLidos, n_pulses);

      // random traffic, including glitches, aborts and occasional resets
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
         if (hold == 0) begin
            botaoIN = ~botaoIN;
            hold = $urandom_range(1, 10);
         end
         hold--;
         if ($urandom_range(0, 15) == 0)     ctrl = 2'($urandom_range(0, 3));
         else if ($urandom_range(0, 7) == 0) ctrl = 2'b10;
         if ($urandom_range(0, 7) == 0) sw = 4'($urandom);
         reset = ($urandom_range(0, 499) != 0);
         step();
      end
      $display("T7 random: cycles=4000 pulses=%0d DadosLidos=%h", n_pulses, DadosLidos);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
